// File: rtl/peripheral_hub_pkg.sv
// Shared register map, bit positions and address decode for the peripheral hub.
package peripheral_hub_pkg;

    localparam int unsigned ADDR_KEY_DATA   = 0;
    localparam int unsigned ADDR_KEY_STATUS = 1;
    localparam int unsigned ADDR_DISP_DATA  = 4;
    localparam int unsigned ADDR_CTRL       = 5;

    localparam int unsigned STAT_COUNT_W    = 8;
    localparam int unsigned STAT_EMPTY_BIT  = 8;
    localparam int unsigned STAT_FULL_BIT   = 9;
    localparam int unsigned STAT_OVF_BIT    = 10;

    localparam int unsigned CTRL_KEY_IRQ_EN_BIT = 0;
    localparam int unsigned CTRL_OVF_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_W              = 2;

    localparam int unsigned KEY_VALID_BIT = 4;
    localparam int unsigned KEY_CODE_W    = 4;

    typedef enum logic [2:0] {
        SEL_KEY_DATA,
        SEL_KEY_STATUS,
        SEL_DISP_DATA,
        SEL_CTRL,
        SEL_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr)
            32'(ADDR_KEY_DATA):   sel = SEL_KEY_DATA;
            32'(ADDR_KEY_STATUS): sel = SEL_KEY_STATUS;
            32'(ADDR_DISP_DATA):  sel = SEL_DISP_DATA;
            32'(ADDR_CTRL):       sel = SEL_CTRL;
            default:              sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/peripheral_hub_key_fifo.sv
// Key-event FIFO: power-of-two depth, push accepted on full only alongside a pop.
module key_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/peripheral_hub.sv
// Register-mapped hub joining the keypad scanner FIFO, the display latch and an irq line.
module peripheral_hub
    import peripheral_hub_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              write_enable,
    input  logic              read_enable,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_update,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // Read handshake: read_enable is a single-cycle request with no backpressure;
    // rvalid answers exactly one cycle later and rdata holds between answers.

    reg_sel_e                sel;
    logic [KEY_CODE_W-1:0]   fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic                    key_pop;
    logic                    pop_fire;
    logic                    ovf_set;
    logic                    ovf_clear;
    logic                    overflow;
    logic [CTRL_W-1:0]       ctrl;
    logic [DATA_W-1:0]       read_word;

    assign sel       = decode_addr(32'(address));
    assign key_pop   = read_enable && (sel == SEL_KEY_DATA);
    assign pop_fire  = key_pop && !fifo_empty;
    assign ovf_set   = key_valid && fifo_full && !pop_fire;
    assign ovf_clear = write_enable && (sel == SEL_KEY_STATUS) && wdata[STAT_OVF_BIT];

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_CODE_W)
    ) u_key_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (key_valid),
        .push_data (key_code),
        .pop       (key_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Read mux sees pre-write state, so a same-cycle write is not reflected.
    always_comb begin
        read_word = '0;
        case (sel)
            SEL_KEY_DATA: begin
                if (!fifo_empty) begin
                    read_word[KEY_VALID_BIT]    = 1'b1;
                    read_word[KEY_CODE_W-1:0]   = fifo_head;
                end
            end
            SEL_KEY_STATUS: begin
                read_word[STAT_COUNT_W-1:0] = STAT_COUNT_W'(fifo_count);
                read_word[STAT_EMPTY_BIT]   = fifo_empty;
                read_word[STAT_FULL_BIT]    = fifo_full;
                read_word[STAT_OVF_BIT]     = overflow;
            end
            SEL_DISP_DATA: read_word = disp_data;
            SEL_CTRL:      read_word[CTRL_W-1:0] = ctrl;
            default:       read_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= read_enable;
            if (read_enable) rdata <= read_word;
        end
    end

    // A new overflow outranks a software clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl        <= '0;
            disp_data   <= '0;
            disp_update <= 1'b0;
        end else begin
            disp_update <= 1'b0;
            if (write_enable && (sel == SEL_CTRL)) begin
                ctrl <= wdata[CTRL_W-1:0];
            end
            if (write_enable && (sel == SEL_DISP_DATA)) begin
                disp_data   <= wdata;
                disp_update <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= (ctrl[CTRL_KEY_IRQ_EN_BIT] && !fifo_empty) ||
                   (ctrl[CTRL_OVF_IRQ_EN_BIT] && overflow);
        end
    end

endmodule

// File: tb/tb_peripheral_hub.sv
// Directed bench for peripheral_hub: key FIFO, status/overflow, display latch, ctrl and irq.
module tb_peripheral_hub;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              write_enable;
  logic              read_enable;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              key_valid;
  logic [3:0]        key_code;
  logic [DATA_W-1:0] disp_data;
  logic              disp_update;
  logic              irq;

  int n_checks = 0;
  int n_fails  = 0;

  // key model: codes expected on KEY_DATA reads, oldest first
  logic [3:0] exp_q[$];

  peripheral_hub #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .wdata        (wdata),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .disp_data    (disp_data),
    .disp_update  (disp_update),
    .irq          (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change on the falling edge, outputs are sampled there too
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    address = a; wdata = d; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    @(negedge clk);
    address = a; read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    check({tag, "_rvalid"}, DATA_W'(rvalid), 1);
    check(tag, rdata, exp);
  endtask

  task automatic push_key(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1; key_code = code;
    @(negedge clk);
    key_valid = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(code);
  endtask

  function automatic logic [DATA_W-1:0] exp_key_word();
    logic [DATA_W-1:0] w;
    w = '0;
    if (exp_q.size() != 0) begin
      w[4] = 1'b1;
      w[3:0] = exp_q.pop_front();
    end
    return w;
  endfunction

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) read_check(tag, 4'h0, exp_key_word());
  endtask

  initial begin
    reset_n = 1'b0; address = '0; wdata = '0; write_enable = 1'b0;
    read_enable = 1'b0; key_valid = 1'b0; key_code = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_rvalid", DATA_W'(rvalid), 0);
    check("rst_disp", disp_data, 0);
    check("rst_disp_upd", DATA_W'(disp_update), 0);
    check("rst_irq", DATA_W'(irq), 0);
    reset_n = 1'b1;

    // empty KEY_DATA read, rvalid only for one cycle
    read_check("empty_key", 4'h0, 32'h0);
    check("irq_idle", DATA_W'(irq), 0);
    @(negedge clk);
    check("rvalid_drop", DATA_W'(rvalid), 0);
    check("rdata_hold", rdata, 0);

    // three keys in order, then empty
    push_key(4'h3); push_key(4'h7); push_key(4'hA);
    read_check("key0", 4'h0, 32'h13);
    read_check("key1", 4'h0, 32'h17);
    read_check("key2", 4'h0, 32'h1A);
    exp_q.delete();
    read_check("key_empty", 4'h0, 32'h0);
    read_check("stat_empty", 4'h1, 32'h100);

    // overflow: five keys into four slots
    for (int i = 1; i <= 5; i++) push_key(4'(i));
    read_check("stat_ovf", 4'h1, 32'h604);
    do_write(4'h1, 32'h400);
    read_check("stat_ovf_clr", 4'h1, 32'h204);
    drain("ovf_drain");
    read_check("ovf_no5th", 4'h0, 32'h0);

    // full FIFO: push and pop in the same cycle
    push_key(4'h6); push_key(4'h7); push_key(4'h8); push_key(4'h9);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'hB; address = 4'h0; read_enable = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; read_enable = 1'b0;
    check("full_pp_rdata", rdata, exp_key_word());
    exp_q.push_back(4'hB);
    read_check("full_pp_stat", 4'h1, 32'h204);
    drain("full_pp_order");

    // empty FIFO: push and pop in the same cycle
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'hC; address = 4'h0; read_enable = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; read_enable = 1'b0;
    check("empty_pp_rdata", rdata, 0);
    exp_q.push_back(4'hC);
    read_check("empty_pp_stat", 4'h1, 32'h001);
    read_check("empty_pp_key", 4'h0, 32'h1C);
    exp_q.delete();

    // new overflow beats a same-cycle clear
    for (int i = 0; i < 4; i++) push_key(4'(i + 8));
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'hF; address = 4'h1; wdata = 32'h400; write_enable = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; write_enable = 1'b0;
    read_check("ovf_wins", 4'h1, 32'h604);
    do_write(4'h1, 32'h400);
    drain("ovf_wins_drain");

    // display latch and pulse
    @(negedge clk);
    address = 4'h4; wdata = 32'h1234; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    check("disp_data", disp_data, 32'h1234);
    check("disp_upd_hi", DATA_W'(disp_update), 1);
    @(negedge clk);
    check("disp_upd_lo", DATA_W'(disp_update), 0);
    read_check("disp_read", 4'h4, 32'h1234);

    // read and write together: read returns the old value
    @(negedge clk);
    address = 4'h4; wdata = 32'h5678; write_enable = 1'b1; read_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0; read_enable = 1'b0;
    check("rw_old", rdata, 32'h1234);
    check("rw_new", disp_data, 32'h5678);

    // ctrl masking, unmapped and read-only accesses
    do_write(4'h5, 32'hFFFF_FFFF);
    read_check("ctrl_mask", 4'h5, 32'h3);
    read_check("unmapped", 4'h2, 32'h0);
    do_write(4'h0, 32'hFFFF_FFFF);
    do_write(4'h7, 32'hFFFF_FFFF);
    read_check("ro_stat", 4'h1, 32'h100);
    read_check("ro_disp", 4'h4, 32'h5678);

    // key irq rises after a push and falls the cycle after the FIFO empties
    do_write(4'h5, 32'h1);
    push_key(4'h2);
    check("irq_lag", DATA_W'(irq), 0);
    @(negedge clk);
    check("irq_rise", DATA_W'(irq), 1);
    read_check("irq_pop", 4'h0, exp_key_word());
    check("irq_hold", DATA_W'(irq), 1);
    @(negedge clk);
    check("irq_fall", DATA_W'(irq), 0);

    // reset mid-operation drops keys and the in-flight read
    push_key(4'h4);
    @(negedge clk);
    check("irq_pre_rst", DATA_W'(irq), 1);
    address = 4'h1; read_enable = 1'b1; reset_n = 1'b0;
    @(negedge clk);
    read_enable = 1'b0; reset_n = 1'b1;
    exp_q.delete();
    check("midrst_rvalid", DATA_W'(rvalid), 0);
    check("midrst_irq", DATA_W'(irq), 0);
    check("midrst_disp", disp_data, 0);
    read_check("midrst_stat", 4'h1, 32'h100);
    read_check("midrst_ctrl", 4'h5, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
